// File: rtl/add_sub_pkg.sv
// Shared constants for the adder-subtractor datapath.
//   ADD_SUB_W_DEFAULT : default operand/result width
//   OP_ADD / OP_SUB   : encoding of the sub operation-select input
package add_sub_pkg;

   localparam int unsigned ADD_SUB_W_DEFAULT = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder, one stage of the ripple-carry chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry in from the previous stage
//   s     : sum bit
//   cout  : carry out to the next stage
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/n_bit_adder_subtractor.sv
// N-bit adder-subtractor with a registered result.
// sub=0 gives a+b; sub=1 gives a-b computed as a + ~b + 1 on the same ripple chain.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset (clears s and c_out)
//   sub    : operation select, 0 = add, 1 = subtract
//   a, b   : operands (a is the minuend when subtracting)
//   c_out  : registered carry out of the MSB stage (1 = no borrow on subtract)
//   s      : registered low N bits of the sum/difference
module n_bit_adder_subtractor
   import add_sub_pkg::*;
#(
   parameter int unsigned N = ADD_SUB_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         c_out,
   output logic [N-1:0] s
);

   logic [N:0]   carry;
   logic [N-1:0] b_eff;
   logic [N-1:0] s_raw;

   logic [N-1:0] s_q;
   logic         c_out_q;

   // The carry-in doubles as the +1 of the two's-complement negation.
   assign carry[0] = sub;

   for (genvar i = 0; i < N; i++) begin : g_stage
      assign b_eff[i] = b[i] ^ sub;

      full_adder_cell u_fa (
         .a    (a[i]),
         .b    (b_eff[i]),
         .cin  (carry[i]),
         .s    (s_raw[i]),
         .cout (carry[i+1])
      );
   end

   // Carry is passed through uninverted, so on subtract it reads as "no borrow".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q     <= '0;
         c_out_q <= 1'b0;
      end else begin
         s_q     <= s_raw;
         c_out_q <= carry[N];
      end
   end

   assign s     = s_q;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_n_bit_adder_subtractor.sv
// Self-checking bench: drives N=4, N=1 and N=8 instances in lock-step and compares
// their registered outputs against a plain-arithmetic reference model.
module tb_n_bit_adder_subtractor;
   import add_sub_pkg::*;

   logic       clk;
   logic       rst;
   logic       sub;
   logic [3:0] a4, b4, s4;
   logic [0:0] a1, b1, s1;
   logic [7:0] a8, b8, s8;
   logic       c4, c1, c8;

   int unsigned n_checks;
   int unsigned n_errors;

   n_bit_adder_subtractor #(.N(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .sub   (sub),
      .a     (a4),
      .b     (b4),
      .c_out (c4),
      .s     (s4)
   );

   n_bit_adder_subtractor #(.N(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .sub   (sub),
      .a     (a1),
      .b     (b1),
      .c_out (c1),
      .s     (s1)
   );

   n_bit_adder_subtractor #(.N(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .sub   (sub),
      .a     (a8),
      .b     (b8),
      .c_out (c8),
      .s     (s8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {carry, result} from unsigned arithmetic on the operand values.
   function automatic int unsigned ref_calc(input int unsigned n, input logic op,
                                            input int unsigned x, input int unsigned y);
      int unsigned mask;
      int unsigned res;
      int unsigned cy;
      mask = (32'd1 << n) - 32'd1;
      if (op == OP_SUB) begin
         res = (x - y) & mask;
         cy  = (x >= y) ? 32'd1 : 32'd0;
      end else begin
         res = (x + y) & mask;
         cy  = ((x + y) > mask) ? 32'd1 : 32'd0;
      end
      return (cy << n) | res;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One operation on all three instances; results checked just after the capturing edge.
   task automatic step(input string tag, input logic op,
                       input logic [3:0] x4, input logic [3:0] y4,
                       input logic [0:0] x1, input logic [0:0] y1,
                       input logic [7:0] x8, input logic [7:0] y8);
      @(negedge clk);
      sub = op;
      a4  = x4;
      b4  = y4;
      a1  = x1;
      b1  = y1;
      a8  = x8;
      b8  = y8;
      @(posedge clk);
      #1;
      check_eq({tag, "_n4"}, 32'({c4, s4}), ref_calc(4, op, 32'(x4), 32'(y4)));
      check_eq({tag, "_n1"}, 32'({c1, s1}), ref_calc(1, op, 32'(x1), 32'(y1)));
      check_eq({tag, "_n8"}, 32'({c8, s8}), ref_calc(8, op, 32'(x8), 32'(y8)));
   endtask

   task automatic step4(input string tag, input logic op, input logic [3:0] x, input logic [3:0] y,
                        input logic [4:0] exp);
      step(tag, op, x, y, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      check_eq({tag, "_dir"}, 32'({c4, s4}), 32'(exp));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      sub = OP_ADD;
      a4 = '0; b4 = '0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;

      #1;
      check_eq("reset_init_n4", 32'({c4, s4}), 32'd0);
      check_eq("reset_init_n8", 32'({c8, s8}), 32'd0);
      @(posedge clk);
      #1;
      check_eq("reset_hold_edge", 32'({c4, s4}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Async reset mid-cycle with nonzero outputs
      step4("pre_rst", OP_ADD, 4'h5, 4'h3, 5'h08);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rst_async_n4", 32'({c4, s4}), 32'd0);
      check_eq("rst_async_n8", 32'({c8, s8}), 32'd0);
      @(posedge clk);
      #1;
      check_eq("rst_held", 32'({c4, s4}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step4("post_rst", OP_ADD, 4'h5, 4'h3, 5'h08);

      // Directed add / subtract cases
      step4("add_f_1", OP_ADD, 4'hF, 4'h1, 5'h10);
      step4("add_9_4", OP_ADD, 4'h9, 4'h4, 5'h0D);
      step4("add_0_0", OP_ADD, 4'h0, 4'h0, 5'h00);
      step4("add_f_f", OP_ADD, 4'hF, 4'hF, 5'h1E);
      step4("sub_f_f", OP_SUB, 4'hF, 4'hF, 5'h10);
      step4("sub_a_3", OP_SUB, 4'hA, 4'h3, 5'h17);
      step4("sub_f_b", OP_SUB, 4'hF, 4'hB, 5'h14);
      step4("sub_3_a", OP_SUB, 4'h3, 4'hA, 5'h09);

      // Width extremes on N=1 and N=8
      step("ext_0m0", OP_SUB, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00);
      step("ext_mpm", OP_ADD, 4'hF, 4'hF, 1'b1, 1'b1, 8'hFF, 8'hFF);
      step("ext_mmm", OP_SUB, 4'hF, 4'hF, 1'b1, 1'b1, 8'hFF, 8'hFF);
      step("ext_0mm", OP_SUB, 4'h0, 4'hF, 1'b0, 1'b1, 8'h00, 8'hFF);
      step("ext_0pm", OP_ADD, 4'h0, 4'hF, 1'b0, 1'b1, 8'h00, 8'hFF);

      // Exhaustive N=4 sweep, back-to-back
      for (int op = 0; op < 2; op++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               step("sweep", 1'(op), 4'(x), 4'(y), 1'(x), 1'(y),
                    8'($urandom), 8'($urandom));
            end
         end
      end

      // Random back-to-back stream
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
